// File: rtl/sram_pkg.sv
// Shared constants, state encoding and mask conversion for the data SRAM front end.
package sram_pkg;

    localparam int SRAM_DEPTH   = 64;
    localparam int SRAM_ADDR_W  = 6;
    localparam int SRAM_DATA_W  = 128;
    localparam int SRAM_BMASK_W = 16;

    localparam logic [SRAM_ADDR_W-1:0] SRAM_LAST_ADDR = SRAM_ADDR_W'(SRAM_DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } arb_state_t;

    // Active-high byte enables to the macro's active-low per-bit mask.
    function automatic logic [SRAM_DATA_W-1:0] bmask_to_bitmask_n(
        input logic [SRAM_BMASK_W-1:0] bmask
    );
        logic [SRAM_DATA_W-1:0] mask_n;
        mask_n = '1;
        for (int b = 0; b < SRAM_BMASK_W; b++) begin
            mask_n[8*b +: 8] = {8{~bmask[b]}};
        end
        return mask_n;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_resp_slot.sv
// Per-requester read-response path: one-cycle bypass of the macro Q plus a
// single hold entry that captures the data when the consumer stalls.
module sram_resp_slot
    import sram_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rd_grant,
    input  logic                   resp_ready,
    input  logic [SRAM_DATA_W-1:0] sram_rdata,
    output logic                   resp_valid,
    output logic [SRAM_DATA_W-1:0] resp_rdata,
    output logic                   rd_eligible
);

    logic                   inflight_q;
    logic                   inflight_d;
    logic                   hold_valid_q;
    logic                   hold_valid_d;
    logic [SRAM_DATA_W-1:0] hold_q;
    logic [SRAM_DATA_W-1:0] hold_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            inflight_q   <= inflight_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end

    always_comb begin
        inflight_d   = rd_grant;
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;

        if (hold_valid_q) begin
            if (resp_ready) begin
                hold_valid_d = 1'b0;
            end
        end else if (inflight_q && !resp_ready) begin
            // Macro Q is only good for one cycle, so park it here.
            hold_valid_d = 1'b1;
            hold_d       = sram_rdata;
        end

        resp_valid  = !reset && (inflight_q || hold_valid_q);
        resp_rdata  = hold_valid_q ? hold_q : sram_rdata;
        rd_eligible = !hold_valid_q && (!inflight_q || resp_ready);
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Front end for the 64 x 128 single-port data SRAM: zeroing sweep after reset,
// then round-robin sharing between two valid/ready requesters.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | sweeping zeros into entries 0..63, one per cycle; no grants
// ST_RUN  | init_done high; at most one granted access per cycle
module sram_port_arbiter
    import sram_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic                    req0_write,
    input  logic [SRAM_ADDR_W-1:0]  req0_addr,
    input  logic [SRAM_BMASK_W-1:0] req0_bmask,
    input  logic [SRAM_DATA_W-1:0]  req0_wdata,
    output logic                    resp0_valid,
    input  logic                    resp0_ready,
    output logic [SRAM_DATA_W-1:0]  resp0_rdata,

    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic                    req1_write,
    input  logic [SRAM_ADDR_W-1:0]  req1_addr,
    input  logic [SRAM_BMASK_W-1:0] req1_bmask,
    input  logic [SRAM_DATA_W-1:0]  req1_wdata,
    output logic                    resp1_valid,
    input  logic                    resp1_ready,
    output logic [SRAM_DATA_W-1:0]  resp1_rdata,

    output logic                    init_done,

    output logic [SRAM_ADDR_W-1:0]  sram_addr,
    output logic                    sram_wen,
    output logic [SRAM_DATA_W-1:0]  sram_wmask,
    output logic [SRAM_DATA_W-1:0]  sram_wdata,
    input  logic [SRAM_DATA_W-1:0]  sram_rdata
);

    arb_state_t             state_q;
    arb_state_t             state_d;
    logic [SRAM_ADDR_W-1:0] cnt_q;
    logic [SRAM_ADDR_W-1:0] cnt_d;
    logic                   rr_q;
    logic                   rr_d;

    logic grant0;
    logic grant1;
    logic elig0;
    logic elig1;
    logic rd_elig0;
    logic rd_elig1;
    logic rd_grant0;
    logic rd_grant1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        grant0     = 1'b0;
        grant1     = 1'b0;
        init_done  = 1'b0;
        sram_addr  = '0;
        sram_wen   = 1'b1;
        sram_wmask = '1;
        sram_wdata = '0;

        elig0 = req0_valid && (req0_write || rd_elig0);
        elig1 = req1_valid && (req1_write || rd_elig1);

        if (!reset) begin
            case (state_q)
                ST_INIT: begin
                    sram_addr  = cnt_q;
                    sram_wen   = 1'b0;
                    sram_wmask = '0;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == SRAM_LAST_ADDR) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    init_done = 1'b1;
                    // rr_q names the port that wins a tie.
                    if (elig0 && elig1) begin
                        grant0 = !rr_q;
                        grant1 = rr_q;
                    end else begin
                        grant0 = elig0;
                        grant1 = elig1;
                    end

                    if (grant0) begin
                        rr_d      = 1'b1;
                        sram_addr = req0_addr;
                        if (req0_write) begin
                            sram_wen   = 1'b0;
                            sram_wdata = req0_wdata;
                            sram_wmask = bmask_to_bitmask_n(req0_bmask);
                        end
                    end else if (grant1) begin
                        rr_d      = 1'b0;
                        sram_addr = req1_addr;
                        if (req1_write) begin
                            sram_wen   = 1'b0;
                            sram_wdata = req1_wdata;
                            sram_wmask = bmask_to_bitmask_n(req1_bmask);
                        end
                    end
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end

        req0_ready = grant0;
        req1_ready = grant1;
        rd_grant0  = grant0 && !req0_write;
        rd_grant1  = grant1 && !req1_write;
    end

    sram_resp_slot u_slot0 (
        .clock       (clock),
        .reset       (reset),
        .rd_grant    (rd_grant0),
        .resp_ready  (resp0_ready),
        .sram_rdata  (sram_rdata),
        .resp_valid  (resp0_valid),
        .resp_rdata  (resp0_rdata),
        .rd_eligible (rd_elig0)
    );

    sram_resp_slot u_slot1 (
        .clock       (clock),
        .reset       (reset),
        .rd_grant    (rd_grant1),
        .resp_ready  (resp1_ready),
        .sram_rdata  (sram_rdata),
        .resp_valid  (resp1_valid),
        .resp_rdata  (resp1_rdata),
        .rd_eligible (rd_elig1)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural macro, transaction-level reference
// model (memory image + one outstanding response per port), directed and random tests.
module tb_sram_port_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset;
    logic [1:0]   valid;
    logic [1:0]   write;
    logic [1:0]   resp_ready;
    logic [5:0]   addr  [2];
    logic [15:0]  bmask [2];
    logic [127:0] wdata [2];
    wire  [1:0]   ready;
    wire  [1:0]   rvalid;
    wire  [127:0] rdata [2];
    wire          init_done;
    wire          sram_wen;
    wire  [5:0]   sram_addr;
    wire  [127:0] sram_wmask;
    wire  [127:0] sram_wdata;
    logic [127:0] sram_rdata;
    logic         scramble;
    logic [127:0] macro_mem [64];

    sram_port_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .req0_valid  (valid[0]),
        .req0_ready  (ready[0]),
        .req0_write  (write[0]),
        .req0_addr   (addr[0]),
        .req0_bmask  (bmask[0]),
        .req0_wdata  (wdata[0]),
        .resp0_valid (rvalid[0]),
        .resp0_ready (resp_ready[0]),
        .resp0_rdata (rdata[0]),
        .req1_valid  (valid[1]),
        .req1_ready  (ready[1]),
        .req1_write  (write[1]),
        .req1_addr   (addr[1]),
        .req1_bmask  (bmask[1]),
        .req1_wdata  (wdata[1]),
        .resp1_valid (rvalid[1]),
        .resp1_ready (resp_ready[1]),
        .resp1_rdata (rdata[1]),
        .init_done   (init_done),
        .sram_addr   (sram_addr),
        .sram_wen    (sram_wen),
        .sram_wmask  (sram_wmask),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
    );

    // Macro: active-low write enable and bit mask, Q registered on read edges.
    always @(posedge clock) begin
        if (scramble) begin
            for (int i = 0; i < 64; i++) macro_mem[i] <= {$urandom, $urandom, $urandom, $urandom};
        end else if (!sram_wen) begin
            macro_mem[sram_addr] <= (macro_mem[sram_addr] & sram_wmask) | (sram_wdata & ~sram_wmask);
        end else begin
            sram_rdata <= macro_mem[sram_addr];
        end
    end

    // Reference model
    logic [127:0] ref_mem [64];
    logic [1:0]   pend;
    logic [127:0] pend_data [2];
    int           pend_age [2];
    logic         prio;
    logic [1:0]   exp_g;
    logic [1:0]   exp_rv;
    logic [127:0] exp_rd [2];
    int           checks;
    int           errors;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        pend = '0;
        pend_age[0] = 0;
        pend_age[1] = 0;
        prio = 1'b0;
    endtask

    task automatic model_eval();
        logic [1:0] e;
        for (int p = 0; p < 2; p++) begin
            exp_rv[p] = pend[p];
            exp_rd[p] = pend_data[p];
            // a new read may go out only once the previous one is leaving on first presentation
            e[p] = valid[p] && (write[p] || !pend[p] || (pend_age[p] == 0 && resp_ready[p]));
        end
        if (e == 2'b11) exp_g = prio ? 2'b10 : 2'b01;
        else            exp_g = e;
    endtask

    task automatic model_commit();
        for (int p = 0; p < 2; p++) begin
            if (pend[p]) begin
                if (resp_ready[p]) pend[p] = 1'b0;
                else               pend_age[p]++;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (exp_g[p]) begin
                prio = (p == 0);
                if (write[p]) begin
                    for (int b = 0; b < 16; b++)
                        if (bmask[p][b]) ref_mem[addr[p]][8*b +: 8] = wdata[p][8*b +: 8];
                end else begin
                    pend[p]      = 1'b1;
                    pend_data[p] = ref_mem[addr[p]];
                    pend_age[p]  = 0;
                end
            end
        end
    endtask

    task automatic next_cycle();
        model_commit();
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        scramble   = 1'b1;
        reset      = 1'b1;
        valid      = 2'b11;
        write      = 2'b00;
        resp_ready = 2'b11;
        repeat (3) @(negedge clock);
        scramble = 1'b0;
        #1;
        checks++; if (ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", ready); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", rvalid); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        checks++; if (sram_wen !== 1'b1) begin errors++; $display("FAIL reset_wen: got %b want 1", sram_wen); end
        checks++; if (sram_addr !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", sram_addr); end
        checks++; if (sram_wmask !== '1) begin errors++; $display("FAIL reset_wmask: got %h want all ones", sram_wmask); end
        checks++; if (sram_wdata !== '0) begin errors++; $display("FAIL reset_wdata: got %h want 0", sram_wdata); end
        @(negedge clock);
        #1;
    endtask

    // Entered with reset high; releases it and follows the sweep for stop_at cycles.
    task automatic test_init(input int stop_at);
        model_reset();
        reset      = 1'b0;
        valid      = 2'b11;
        write      = 2'b00;
        resp_ready = 2'b11;
        addr[0]    = 6'($urandom_range(0, 63));
        addr[1]    = 6'($urandom_range(0, 63));
        for (int c = 0; c < stop_at; c++) begin
            #1;
            checks++; if (sram_wen !== 1'b0 || sram_addr !== 6'(c) || sram_wmask !== '0 || sram_wdata !== '0) begin
                errors++; $display("FAIL init_sweep c=%0d: wen=%b addr=%0d wmask=%h wdata=%h want wen=0 addr=%0d zero mask/data",
                                   c, sram_wen, sram_addr, sram_wmask, sram_wdata, c);
            end
            checks++; if (ready !== 2'b00 || init_done !== 1'b0) begin
                errors++; $display("FAIL init_ready c=%0d: ready=%b init_done=%b want 00/0", c, ready, init_done);
            end
            @(negedge clock);
            #1;
        end
        if (stop_at == 64) begin
            #1;
            model_eval();
            checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_rise: got %b want 1", init_done); end
            checks++; if (ready !== exp_g) begin errors++; $display("FAIL init_first_grant: got %b want %b", ready, exp_g); end
            checks++; if (sram_wen !== 1'b1 || sram_addr !== addr[0]) begin
                errors++; $display("FAIL init_first_read: wen=%b addr=%0d want 1/%0d", sram_wen, sram_addr, addr[0]);
            end
            next_cycle();
            valid = 2'b00;
            #1;
            model_eval();
            checks++; if (rvalid !== exp_rv) begin errors++; $display("FAIL init_resp_valid: got %b want %b", rvalid, exp_rv); end
            checks++; if (rdata[0] !== 128'h0) begin errors++; $display("FAIL init_zeroed: got %h want 0", rdata[0]); end
            next_cycle();
        end
    endtask

    task automatic test_single_read();
        logic [127:0] d;
        d = {16{8'hA5}};
        valid = 2'b01; write[0] = 1'b1; addr[0] = 6'd5; bmask[0] = 16'hFFFF; wdata[0] = d;
        #1; model_eval();
        checks++; if (ready !== 2'b01 || sram_wen !== 1'b0 || sram_addr !== 6'd5) begin
            errors++; $display("FAIL single_write: ready=%b wen=%b addr=%0d want 01/0/5", ready, sram_wen, sram_addr);
        end
        next_cycle();
        write[0] = 1'b0;
        #1; model_eval();
        checks++; if (ready !== 2'b01 || sram_wen !== 1'b1) begin
            errors++; $display("FAIL single_read_grant: ready=%b wen=%b want 01/1", ready, sram_wen);
        end
        next_cycle();
        valid = 2'b00;
        #1; model_eval();
        checks++; if (rvalid !== 2'b01 || rdata[0] !== d) begin
            errors++; $display("FAIL single_read_data: rvalid=%b rdata=%h want 01/%h", rvalid, rdata[0], d);
        end
        next_cycle();
        #1; model_eval();
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL single_read_once: rvalid=%b want 00", rvalid); end
        next_cycle();
    endtask

    task automatic test_bmask();
        logic [127:0] exp_m;
        exp_m = {{120{1'b1}}, 8'h00};
        valid = 2'b01; write[0] = 1'b1; addr[0] = 6'd9; bmask[0] = 16'hFFFF; wdata[0] = '1;
        #1; model_eval(); next_cycle();
        bmask[0] = 16'h0001; wdata[0] = '0;
        #1; model_eval();
        checks++; if (sram_wmask !== exp_m) begin errors++; $display("FAIL bmask_wmask: got %h want %h", sram_wmask, exp_m); end
        next_cycle();
        write[0] = 1'b0;
        #1; model_eval(); next_cycle();
        valid = 2'b00;
        #1; model_eval();
        checks++; if (rvalid[0] !== 1'b1 || rdata[0] !== exp_m || rdata[0] !== exp_rd[0]) begin
            errors++; $display("FAIL bmask_read: rvalid=%b rdata=%h want 1/%h", rvalid[0], rdata[0], exp_m);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [127:0] d1, d2;
        logic [1:0]   want_rv;
        d1 = {4{32'h1111_0001}};
        d2 = {4{32'h2222_0002}};
        reset = 1'b1; valid = 2'b00;
        @(negedge clock); #1;
        test_init(64);
        valid = 2'b01; write = 2'b11; addr[0] = 6'd1; bmask[0] = 16'hFFFF; wdata[0] = d1;
        #1; model_eval(); next_cycle();
        valid = 2'b10; addr[1] = 6'd2; bmask[1] = 16'hFFFF; wdata[1] = d2;
        #1; model_eval(); next_cycle();
        valid = 2'b11; write = 2'b00; addr[0] = 6'd1; addr[1] = 6'd2; resp_ready = 2'b11;
        for (int k = 0; k < 8; k++) begin
            #1; model_eval();
            checks++; if (ready !== ((k % 2 == 0) ? 2'b01 : 2'b10) || ready !== exp_g) begin
                errors++; $display("FAIL rr_grant k=%0d: got %b want %b", k, ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            want_rv = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
            checks++; if (rvalid !== want_rv) begin errors++; $display("FAIL rr_rvalid k=%0d: got %b want %b", k, rvalid, want_rv); end
            if (want_rv[0]) begin
                checks++; if (rdata[0] !== d1) begin errors++; $display("FAIL rr_data0 k=%0d: got %h want %h", k, rdata[0], d1); end
            end
            if (want_rv[1]) begin
                checks++; if (rdata[1] !== d2) begin errors++; $display("FAIL rr_data1 k=%0d: got %h want %h", k, rdata[1], d2); end
            end
            next_cycle();
        end
        valid = 2'b00;
        #1; model_eval(); next_cycle();
    endtask

    task automatic test_backpressure();
        logic [127:0] d3;
        d3 = {16{8'h3C}};
        valid = 2'b01; write[0] = 1'b1; addr[0] = 6'd3; bmask[0] = 16'hFFFF; wdata[0] = d3;
        #1; model_eval(); next_cycle();
        addr[0] = 6'd0; wdata[0] = {16{8'hC3}};
        #1; model_eval(); next_cycle();
        valid = 2'b10; write[1] = 1'b0; addr[1] = 6'd3; resp_ready = 2'b01;
        #1; model_eval();
        checks++; if (ready !== 2'b10) begin errors++; $display("FAIL bp_grant: got %b want 10", ready); end
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            #1; model_eval();
            checks++; if (ready !== 2'b00 || rvalid[1] !== 1'b1 || rdata[1] !== d3) begin
                errors++; $display("FAIL bp_stall k=%0d: ready=%b rvalid1=%b rdata1=%h want 00/1/%h", k, ready, rvalid[1], rdata[1], d3);
            end
            next_cycle();
        end
        write[1] = 1'b1; addr[1] = 6'd4; bmask[1] = 16'hFFFF; wdata[1] = {4{$urandom}};
        #1; model_eval();
        checks++; if (ready !== 2'b10 || rvalid[1] !== 1'b1 || rdata[1] !== d3) begin
            errors++; $display("FAIL bp_write_while_held: ready=%b rvalid1=%b rdata1=%h want 10/1/%h", ready, rvalid[1], rdata[1], d3);
        end
        next_cycle();
        valid = 2'b00; resp_ready = 2'b11;
        #1; model_eval();
        checks++; if (rvalid[1] !== 1'b1 || rdata[1] !== d3) begin
            errors++; $display("FAIL bp_drain: rvalid1=%b rdata1=%h want 1/%h", rvalid[1], rdata[1], d3);
        end
        next_cycle();
        #1; model_eval();
        checks++; if (rvalid[1] !== 1'b0) begin errors++; $display("FAIL bp_drained: rvalid1=%b want 0", rvalid[1]); end
        next_cycle();
    endtask

    task automatic test_reset_midop();
        valid = 2'b10; write[1] = 1'b0; addr[1] = 6'd3; resp_ready = 2'b01;
        #1; model_eval();
        checks++; if (ready !== 2'b10) begin errors++; $display("FAIL midop_grant: got %b want 10", ready); end
        next_cycle();
        valid = 2'b00;
        #1; model_eval(); next_cycle();
        reset = 1'b1;
        #1;
        checks++; if (rvalid !== 2'b00 || ready !== 2'b00 || init_done !== 1'b0) begin
            errors++; $display("FAIL midop_reset_held: rvalid=%b ready=%b init_done=%b want 00/00/0", rvalid, ready, init_done);
        end
        @(negedge clock); #1;
        test_init(64);
        reset = 1'b1; valid = 2'b00;
        @(negedge clock); #1;
        test_init(30);
        reset = 1'b1;
        #1;
        checks++; if (sram_wen !== 1'b1 || sram_addr !== 6'd0) begin
            errors++; $display("FAIL midop_reset_sweep: wen=%b addr=%0d want 1/0", sram_wen, sram_addr);
        end
        @(negedge clock); #1;
        test_init(64);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            valid = 2'($urandom);
            write = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                addr[p]       = 6'($urandom_range(0, 7));
                bmask[p]      = 16'($urandom);
                wdata[p]      = {$urandom, $urandom, $urandom, $urandom};
                resp_ready[p] = ($urandom_range(0, 3) != 0);
            end
            #1; model_eval();
            checks++; if (ready !== exp_g) begin errors++; $display("FAIL rand_grant k=%0d: got %b want %b", k, ready, exp_g); end
            checks++; if (rvalid !== exp_rv) begin errors++; $display("FAIL rand_rvalid k=%0d: got %b want %b", k, rvalid, exp_rv); end
            for (int p = 0; p < 2; p++) begin
                if (exp_rv[p]) begin
                    checks++; if (rdata[p] !== exp_rd[p]) begin
                        errors++; $display("FAIL rand_rdata%0d k=%0d: got %h want %h", p, k, rdata[p], exp_rd[p]);
                    end
                end
                if (exp_g[p]) begin
                    checks++; if (sram_addr !== addr[p] || sram_wen !== !write[p]) begin
                        errors++; $display("FAIL rand_sram%0d k=%0d: addr=%0d wen=%b want %0d/%b", p, k, sram_addr, sram_wen, addr[p], !write[p]);
                    end
                end
            end
            if (exp_g == 2'b00) begin
                checks++; if (sram_wen !== 1'b1) begin errors++; $display("FAIL rand_idle k=%0d: wen=%b want 1", k, sram_wen); end
            end
            next_cycle();
        end
        valid = 2'b00; resp_ready = 2'b11;
        #1; model_eval(); next_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        scramble = 1'b0;
        reset = 1'b1;
        valid = '0; write = '0; resp_ready = '1;
        for (int p = 0; p < 2; p++) begin
            addr[p] = '0; bmask[p] = '0; wdata[p] = '0; pend_data[p] = '0;
        end
        model_reset();
        @(negedge clock); #1;
        test_reset();
        test_init(64);
        test_single_read();
        test_bmask();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Front-end controller for the 64 x 128-bit single-port data SRAM macro.
- After reset, runs an init sweep that zeroes all 64 entries.
- Then shares the single port between two requesters (req0, req1) using round-robin arbitration with valid/ready handshakes.
- Converts active-high byte-mask writes into the macro's active-low write enable and active-low bit mask.
- Returns read data with a one-entry response hold slot per requester, to absorb backpressure.

Parameters:
- DEPTH, 64, number of SRAM entries; address width = clog2(DEPTH) = 6.
- DATA_W, 128, SRAM word width; byte mask width = DATA_W/8 = 16.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- reqN_valid  in  1  request valid, N = 0, 1.
- reqN_ready  out  1  request accepted when valid & ready.
- reqN_write  in  1  1 = write, 0 = read.
- reqN_addr  in  6  entry index.
- reqN_bmask  in  16  active-high byte enables (writes only).
- reqN_wdata  in  128  write data.
- respN_valid  out  1  read data valid.
- respN_ready  in  1  consumer accepts read data.
- respN_rdata  out  128  read data.
- init_done  out  1  high once the sweep completes.
- sram_addr  out  6  macro address.
- sram_wen  out  1  macro write enable, active-low (0 = write, 1 = read/idle).
- sram_wmask  out  128  macro bit mask, active-low (0 = bit written).
- sram_wdata  out  128  macro write data.
- sram_rdata  in  128  macro Q output; valid the cycle after a read-addressed edge.

Behaviour:
- States: INIT, RUN.
- Reset: state = INIT, sweep counter = 0, rr pointer = 0 (req0 wins first tie).
  - All inflight, hold_valid and grant registers clear.
  - While reset is high: req_ready = 0, resp_valid = 0, init_done = 0, sram_wen = 1, sram_addr = 0, sram_wmask = all 1s, sram_wdata = 0.
- INIT, one entry per cycle:
  - sram_addr = counter, sram_wen = 0, sram_wmask = 0, sram_wdata = 0.
  - Counter increments each cycle; after the write at address 63, go to RUN. Sweep takes 64 cycles.
  - reqN_ready = 0 throughout INIT.
- RUN: init_done = 1. At most one SRAM access per cycle.
- Eligibility:
  - A write from port N is always eligible.
  - A read from port N is eligible iff !holdN_valid & (!inflightN | respN_ready).
  - This is a combinational path from respN_ready to reqN_ready; it is intended.
- Arbitration:
  - If exactly one port is valid and eligible, grant it.
  - If both are, grant the port not granted most recently.
  - rr pointer updates only on a grant.
  - reqN_ready = grantN. Ready is never asserted to a port lacking valid.
- Granted cycle T drives the SRAM combinationally:
  - sram_addr = addr.
  - Write: sram_wen = 0; sram_wdata = wdata; sram_wmask[8b+7:8b] = ~{8{bmask[b]}}.
  - Read: sram_wen = 1, sram_wmask = all 1s.
- No grant in RUN: sram_wen = 1, sram_addr = 0, sram_wmask = all 1s (idle read, result discarded).
- Read response:
  - inflightN set at edge T, meaning it is high in cycle T+1.
  - In T+1: respN_valid = 1, respN_rdata = sram_rdata (bypass, latency 1).
  - If respN_ready = 0 in T+1: holdN <= sram_rdata, holdN_valid <= 1.
  - While holdN_valid: respN_valid = 1, respN_rdata = holdN. Clears on respN_ready.
  - inflightN clears in T+2 unless a new read from N was granted in T+1.
- Writes produce no response. Write-then-read to the same address on consecutive cycles returns the new data (macro is sequential).
- Back-to-back reads from one port at 1/cycle are sustained while respN_ready = 1.
- Both ports write the same address: only one is granted per cycle; last grant wins.
- Reset mid-operation (either state): all state is discarded and the sweep restarts from 0; any pending response is dropped.

Decomposition:
- Shared package sram_pkg:
  - SRAM_DEPTH = 64, SRAM_ADDR_W = 6, SRAM_DATA_W = 128, SRAM_BMASK_W = 16.
  - State enum {ST_INIT, ST_RUN}.
  - Function bmask_to_bitmask_n (16 -> 128, inverted).
- Sub-module sram_resp_slot, instantiated twice:
  - Holds inflight, hold register and hold_valid.
  - Produces resp_valid/resp_rdata and the port's read-eligible flag.

Test Plan:
- Init: release reset, no requests -> sram_wen = 0 for exactly 64 cycles with sram_addr 0..63 and sram_wmask = 0. init_done rises in cycle 65; req ready is 0 until then.
- Single read: after init, req0 write addr 5, bmask 16'hFFFF, data 128'hA5..A5; then read addr 5 -> resp0_valid exactly one cycle after the grant, rdata = 128'hA5..A5.
- Byte mask: write addr 9 with all F's, then write 0 with bmask 16'h0001 -> read returns 128'hFF..FF00; sram_wmask on the second write = 128'hFF..FF00.
- Round robin: both ports hold reads to addr 1 and addr 2 continuously, resp_ready = 1 -> grants alternate 0, 1, 0, 1 starting with req0; each response carries its own address's data.
- Backpressure:
  - resp1_ready = 0; req1 reads addr 3 -> data captured in hold, resp1_valid stays high, req1_ready = 0 for further reads.
  - Writes from req1 are still granted.
  - Raise resp1_ready -> hold drains in one cycle.
- Reset mid-op: assert reset during a held response and again at sweep count 30 -> resp_valid drops, sweep restarts at address 0 and runs a full 64 cycles.
